// File: rtl/bcd_pkg.sv
// Shared types and constants for the BCD down-timer: FSM state encoding,
// digit width and the per-digit clamp used when loading presets.
package bcd_pkg;

    localparam int BCD_W = 4;
    localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } bcd_state_e;

    // Nibbles above 9 are not valid BCD; saturate them to 9.
    function automatic logic [BCD_W-1:0] bcd_clamp(input logic [BCD_W-1:0] d);
        return (d > BCD_MAX) ? BCD_MAX : d;
    endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// One BCD digit of the down-counter: parallel load, or decrement with
// 0 -> 9 wrap when the borrow chain enables it.
module bcd_down_digit
    import bcd_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [BCD_W-1:0] load_digit,
    input  logic             dec,
    output logic [BCD_W-1:0] q,
    output logic             is_zero
);

    logic [BCD_W-1:0] q_q;
    logic [BCD_W-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (load) begin
            q_d = load_digit;
        end else if (dec) begin
            q_d = (q_q == '0) ? BCD_MAX : (q_q - 4'd1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q       = q_q;
    assign is_zero = (q_q == '0);

endmodule

// File: rtl/bcd_down_timer.sv
// Multi-digit BCD countdown timer with load/start/pause and a one-cycle done
// pulse. Define BCD_DOWN_AUTO_RELOAD_EN to reload instead of stopping at zero.
module bcd_down_timer
    import bcd_pkg::*;
#(
    parameter int DIGITS = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic [4*DIGITS-1:0] load_val,
    input  logic                start,
    input  logic                pause,
    input  logic                tick,
    output logic [4*DIGITS-1:0] q,
    output logic                busy,
    output logic                done
);

    localparam int W = BCD_W * DIGITS;

`ifdef BCD_DOWN_AUTO_RELOAD_EN
    localparam bit AUTO_RELOAD = 1'b1;
`else
    localparam bit AUTO_RELOAD = 1'b0;
`endif

    bcd_state_e state_q, state_d;
    logic [W-1:0] reload_q, reload_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;

    logic [W-1:0]      load_clamped;
    logic [W-1:0]      q_int;
    logic [W-1:0]      dig_src;
    logic              dig_load;
    logic              count_en;
    logic [DIGITS-1:0] dig_zero;
    logic [DIGITS-1:0] dig_dec;
    logic [DIGITS:0]   lower_zero;
    logic              all_zero;
    logic              is_one;
    logic              reload_zero;

    always_comb begin
        load_clamped = '0;
        for (int i = 0; i < DIGITS; i++) begin
            load_clamped[i*BCD_W +: BCD_W] = bcd_clamp(load_val[i*BCD_W +: BCD_W]);
        end
    end

    // lower_zero[i] is high when every digit below i reads zero (the borrow).
    always_comb begin
        lower_zero    = '0;
        lower_zero[0] = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            lower_zero[i+1] = lower_zero[i] & dig_zero[i];
        end
    end

    assign all_zero    = lower_zero[DIGITS];
    assign dig_dec     = {DIGITS{count_en}} & lower_zero[DIGITS-1:0];
    assign is_one      = (q_int == W'(1));
    assign reload_zero = (reload_q == '0);

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_down_digit u_digit (
            .clk        (clk),
            .rst_n      (rst_n),
            .load       (dig_load),
            .load_digit (dig_src[g*BCD_W +: BCD_W]),
            .dec        (dig_dec[g]),
            .q          (q_int[g*BCD_W +: BCD_W]),
            .is_zero    (dig_zero[g])
        );
    end

    // Control FSM: load beats everything, then start, pause and tick.
    always_comb begin
        state_d  = state_q;
        reload_d = reload_q;
        done_d   = 1'b0;
        dig_load = 1'b0;
        dig_src  = reload_q;
        count_en = 1'b0;

        if (load) begin
            state_d  = IDLE;
            reload_d = load_clamped;
            dig_load = 1'b1;
            dig_src  = load_clamped;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (all_zero) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = RUN;
                        end
                    end
                end
                RUN: begin
                    if (pause) begin
                        state_d = PAUSE;
                    end else if (tick && !all_zero) begin
                        count_en = 1'b1;
                        if (is_one) begin
                            done_d = 1'b1;
                            if (AUTO_RELOAD && !reload_zero) begin
                                dig_load = 1'b1;
                            end else begin
                                state_d = DONE;
                            end
                        end
                    end
                end
                PAUSE: begin
                    if (!pause) begin
                        state_d = RUN;
                    end
                end
                DONE: begin
                    // Holding start with a zero reload must not stretch done.
                    if (start) begin
                        if (!reload_zero) begin
                            dig_load = 1'b1;
                            state_d  = RUN;
                        end else begin
                            done_d = !done_q;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        busy_d = (state_d == RUN) || (state_d == PAUSE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            reload_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            reload_q <= reload_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign q    = q_int;
    assign busy = busy_q;
    assign done = done_q;

endmodule
